imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes the RISC-V immediate at push and buffers the result in a 2-entry FIFO.
// Latency 1 cycle from push to head; in_ready = occupancy < 2, registered only, no path from out_ready.
// Backpressure: when both slots are full the upstream word is held; head fields stay stable until popped.

module imm_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    logic [1:0]   occ;
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         do_push;
    logic         do_pop;

    assign push_rdy = (occ < 2'd2);
    assign pop_vld  = (occ != 2'd0);
    assign pop_dat  = slot0;
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    // slot0 is always the head; a pop shifts slot1 forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (do_push && !do_pop) begin
                if (occ == 2'd0) slot0 <= push_dat;
                else             slot1 <= push_dat;
                occ <= occ + 2'd1;
            end else if (!do_push && do_pop) begin
                slot0 <= slot1;
                occ   <= occ - 2'd1;
            end else if (do_push && do_pop) begin
                if (occ == 2'd1) begin
                    slot0 <= push_dat;
                end else begin
                    slot0 <= slot1;
                    slot1 <= push_dat;
                end
            end
        end
    end
endmodule

module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ZICSR_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [31:0]     dec_count
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    entry_t      dec_dat;
    entry_t      head_dat;
    logic [31:0] imm32;
    logic [2:0]  dec_type;
    logic        dec_ill;
    logic [6:0]  opcode;

    assign opcode = in_instr[6:0];

    always_comb begin
        imm32    = 32'd0;
        dec_type = T_NONE;
        dec_ill  = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (opcode)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                    dec_type = T_I;
                    imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                7'b0100011: begin
                    dec_type = T_S;
                    imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                7'b1100011: begin
                    dec_type = T_B;
                    imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
                end
                7'b1101111: begin
                    dec_type = T_J;
                    imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_type = T_U;
                    imm32    = {in_instr[31:12], 12'b0};
                end
                7'b1110011: begin
                    if (ZICSR_EN != 0) begin
                        dec_type = T_Z;
                        imm32    = {27'd0, in_instr[19:15]};
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                7'b0110011: dec_type = T_NONE;
                // RV64 word ops only exist when XLEN is 64.
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_type = T_I;
                        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                7'b0111011: dec_ill = (XLEN != 64);
                default:    dec_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        dec_dat          = '0;
        dec_dat.instr    = in_instr;
        dec_dat.imm      = XLEN'($signed(imm32));
        dec_dat.imm_type = dec_type;
        dec_dat.illegal  = dec_ill;
    end

    imm_fifo2 #(.W($bits(entry_t))) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (dec_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign out_instr    = head_dat.instr;
    assign out_imm      = head_dat.imm;
    assign out_imm_type = head_dat.imm_type;
    assign out_illegal  = head_dat.illegal;

    always_ff @(posedge clk) begin
        if (!rst_n)                      dec_count <= 32'd0;
        else if (out_valid && out_ready) dec_count <= dec_count + 32'd1;
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an XLEN=32 and an XLEN=64 instance driven in lockstep,
// checked against constant vectors and a queue-based reference model.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] instr32, imm32, cnt32;
    logic [2:0]  typ32;
    logic        in_ready64, out_valid64, ill64;
    logic [31:0] instr64, cnt64;
    logic [63:0] imm64;
    logic [2:0]  typ64;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    logic [31:0] mcount;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .ZICSR_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_instr(instr32), .out_imm(imm32), .out_imm_type(typ32),
        .out_illegal(ill32), .dec_count(cnt32));

    imm_decode_stage #(.XLEN(64), .ZICSR_EN(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(instr64), .out_imm(imm64), .out_imm_type(typ64),
        .out_illegal(ill64), .dec_count(cnt64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference decoder: immediate as a signed integer value, then truncated to XLEN.
    function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] t,
                                    output logic ill);
        longint v;
        v = 0; t = 0; ill = 0;
        if (i[1:0] != 2'b11) ill = 1;
        else case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F: begin t = 1; v = $signed(i[31:20]); end
            7'h23: begin t = 2; v = $signed({i[31:25], i[11:7]}); end
            7'h63: begin t = 3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h6F: begin t = 5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'h37, 7'h17: begin t = 4; v = $signed({i[31:12], 12'b0}); end
            7'h73: begin t = 6; v = longint'(i[19:15]); end
            7'h33: t = 0;
            7'h1B: if (xlen == 64) begin t = 1; v = $signed(i[31:20]); end else ill = 1;
            7'h3B: ill = (xlen != 64);
            default: ill = 1;
        endcase
        imm = (xlen == 64) ? 64'(v) : {32'd0, v[31:0]};
    endfunction

    task automatic check_model();
        logic [63:0] e_imm;
        logic [2:0]  e_t;
        logic        e_ill;
        chk("in_ready32", {63'd0, in_ready32}, {63'd0, mq.size() < 2});
        chk("in_ready64", {63'd0, in_ready64}, {63'd0, mq.size() < 2});
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, mq.size() > 0});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, mq.size() > 0});
        chk("dec_count32", {32'd0, cnt32}, {32'd0, mcount});
        chk("dec_count64", {32'd0, cnt64}, {32'd0, mcount});
        if (mq.size() > 0) begin
            ref_dec(mq[0], 32, e_imm, e_t, e_ill);
            chk("instr32", {32'd0, instr32}, {32'd0, mq[0]});
            chk("imm32", {32'd0, imm32}, e_imm);
            chk("type32", {61'd0, typ32}, {61'd0, e_t});
            chk("ill32", {63'd0, ill32}, {63'd0, e_ill});
            ref_dec(mq[0], 64, e_imm, e_t, e_ill);
            chk("instr64", {32'd0, instr64}, {32'd0, mq[0]});
            chk("imm64", imm64, e_imm);
            chk("type64", {61'd0, typ64}, {61'd0, e_t});
            chk("ill64", {63'd0, ill64}, {63'd0, e_ill});
        end
    endtask

    // One clock: drive inputs, check mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic r);
        logic do_push, do_pop;
        in_valid = v; in_instr = ins; out_ready = r;
        @(negedge clk);
        check_model();
        do_push = v && (mq.size() < 2);
        do_pop  = r && (mq.size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mcount = 0;
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                mcount = mcount + 1;
            end
            if (do_push) mq.push_back(ins);
        end
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm_32;
        logic [2:0]  t_32;
        logic        ill_32;
        logic [63:0] imm_64;
        logic [2:0]  t_64;
        logic        ill_64;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0};
        tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0};
        tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3, 0, 64'hFFFFFFFFFFFFFFF8, 3, 0};
        tbl[3]  = '{32'h800000B7, 32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0};
        tbl[4]  = '{32'h0000001B, 32'h00000000, 0, 1, 64'h0, 1, 0};
        tbl[5]  = '{32'h00000000, 32'h00000000, 0, 1, 64'h0, 0, 1};
        tbl[6]  = '{32'h00000033, 32'h00000000, 0, 0, 64'h0, 0, 0};
        tbl[7]  = '{32'h0040006F, 32'h00000004, 5, 0, 64'h4, 5, 0};
        tbl[8]  = '{32'h000F9073, 32'h0000001F, 6, 0, 64'h1F, 6, 0};
        tbl[9]  = '{32'h0000003B, 32'h00000000, 0, 1, 64'h0, 0, 0};
        tbl[10] = '{32'hFFF00090, 32'h00000000, 0, 1, 64'h0, 0, 1};
        tbl[11] = '{32'hFFFFF017, 32'hFFFFF000, 4, 0, 64'hFFFFFFFFFFFFF000, 4, 0};
        tbl[12] = '{32'h80002003, 32'hFFFFF800, 1, 0, 64'hFFFFFFFFFFFFF800, 1, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        mcount = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset out_valid", {63'd0, out_valid32 | out_valid64}, 64'd0);
        chk("reset in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
        chk("reset dec_count", {cnt32, cnt64}, 64'd0);

        // Constant vectors: push into empty FIFO, check head one edge later, then pop.
        for (int k = 0; k < 13; k++) begin
            cycle(1'b1, tbl[k].instr, 1'b0);
            chk("tbl valid", {62'd0, out_valid32, out_valid64}, 64'd3);
            chk($sformatf("tbl%0d imm32", k), {32'd0, imm32}, {32'd0, tbl[k].imm_32});
            chk($sformatf("tbl%0d type32", k), {61'd0, typ32}, {61'd0, tbl[k].t_32});
            chk($sformatf("tbl%0d ill32", k), {63'd0, ill32}, {63'd0, tbl[k].ill_32});
            chk($sformatf("tbl%0d imm64", k), imm64, tbl[k].imm_64);
            chk($sformatf("tbl%0d type64", k), {61'd0, typ64}, {61'd0, tbl[k].t_64});
            chk($sformatf("tbl%0d ill64", k), {63'd0, ill64}, {63'd0, tbl[k].ill_64});
            cycle(1'b0, 32'd0, 1'b1);
        end

        // Back-to-back sw/beq with out_ready high, from a fresh reset.
        rst_n = 1'b0; cycle(1'b0, 32'd0, 1'b0); rst_n = 1'b1;
        cycle(1'b1, 32'hFE112E23, 1'b1);
        chk("sw imm", {32'd0, imm32}, 64'hFFFFFFFC);
        cycle(1'b1, 32'hFE000CE3, 1'b1);
        chk("beq imm", {32'd0, imm32}, 64'hFFFFFFF8);
        chk("beq type", {61'd0, typ32}, 64'd3);
        cycle(1'b0, 32'd0, 1'b1);
        chk("sw/beq dec_count", {32'd0, cnt32}, 64'd2);

        // Backpressure: third word held upstream until a slot frees.
        rst_n = 1'b0; cycle(1'b0, 32'd0, 1'b0); rst_n = 1'b1;
        cycle(1'b1, 32'h00100093, 1'b0);
        cycle(1'b1, 32'h00200093, 1'b0);
        chk("full in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
        cycle(1'b1, 32'h00300093, 1'b0);
        chk("held head", {32'd0, instr32}, 64'h00100093);
        cycle(1'b1, 32'h00300093, 1'b1);
        cycle(1'b1, 32'h00300093, 1'b1);
        chk("order head", {32'd0, instr32}, 64'h00300093);
        cycle(1'b0, 32'd0, 1'b1);
        chk("bp dec_count", {32'd0, cnt32}, 64'd3);
        chk("bp empty", {62'd0, out_valid32, out_valid64}, 64'd0);

        // Reset while full, with in_valid asserted during the reset cycle.
        cycle(1'b1, 32'h00400093, 1'b0);
        cycle(1'b1, 32'h00500093, 1'b0);
        rst_n = 1'b0;
        cycle(1'b1, 32'h00600093, 1'b0);
        rst_n = 1'b1;
        chk("rst out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
        chk("rst in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
        chk("rst dec_count", {cnt32, cnt64}, 64'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            logic [6:0]  ops [14];
            ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h6F,
                    7'h37, 7'h17, 7'h73, 7'h33, 7'h1B, 7'h3B, 7'h7F};
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 13)];
            if (n == 300) rst_n = 1'b0;
            cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
            rst_n = 1'b1;
        end
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
